// File: rtl/bud_ctrl.sv
// Alarm FSM: compares BCD now/alarm time, rings with timeout, snooze and stop.
// Latency: one edge from match/button/bud_en to state and aud_en; no backpressure.
// Backpressure: none, pulses and levels are consumed every cycle.
module bud_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bud_en,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    input  logic [3:0] hourdec_bud,
    input  logic [3:0] hourone_bud,
    input  logic [3:0] mindec_bud,
    input  logic [3:0] minone_bud,
    input  logic [5:0] cnt_sec,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       aud_en,
    output logic [2:0] bud_state,
    output logic [1:0] snooze_cnt
);
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_MAX = RW'(RING_SEC);
    localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_SEC);
    localparam logic [2:0]    SNZ_LIM  = 3'(MAX_SNOOZE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RING    = 3'd2,
        SNOOZE  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t        state;
    logic [5:0]    cnt_sec_q;
    logic [RW-1:0] ring_cnt;
    logic [RW-1:0] ring_nxt;
    logic [SW-1:0] snz_tmr;
    logic [SW-1:0] snz_nxt;
    logic          match;
    logic          tick;
    logic          snooze_ok;

    // Counters look one tick ahead so a timeout lands on the edge that closes the last second.
    always_comb begin
        match = ({hourdec_now, hourone_now, mindec_now, minone_now} ==
                 {hourdec_bud, hourone_bud, mindec_bud, minone_bud});
        tick  = (cnt_sec != cnt_sec_q);
        ring_nxt = ring_cnt;
        if (tick && ring_cnt != RING_MAX)
            ring_nxt = ring_cnt + RW'(1);
        snz_nxt = snz_tmr;
        if (tick && snz_tmr != SNZ_MAX)
            snz_nxt = snz_tmr + SW'(1);
        snooze_ok = snooze_btn && ({1'b0, snooze_cnt} < SNZ_LIM);
    end

    assign bud_state = state;

    always_ff @(posedge clk) begin
        cnt_sec_q <= cnt_sec;
        if (rst) begin
            state      <= IDLE;
            aud_en     <= 1'b0;
            snooze_cnt <= 2'd0;
            ring_cnt   <= '0;
            snz_tmr    <= '0;
        end else if (!bud_en) begin
            state      <= IDLE;
            aud_en     <= 1'b0;
            snooze_cnt <= 2'd0;
        end else begin
            aud_en <= 1'b0;
            case (state)
                IDLE: begin
                    snooze_cnt <= 2'd0;
                    // Arming inside the alarm minute must not ring for that minute.
                    state <= match ? LOCKOUT : ARMED;
                end
                ARMED: begin
                    if (match) begin
                        state      <= RING;
                        aud_en     <= 1'b1;
                        ring_cnt   <= '0;
                        snooze_cnt <= 2'd0;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state <= LOCKOUT;
                    end else if (snooze_ok) begin
                        state      <= SNOOZE;
                        snooze_cnt <= snooze_cnt + 2'd1;
                        snz_tmr    <= '0;
                    end else begin
                        ring_cnt <= ring_nxt;
                        if (ring_nxt == RING_MAX)
                            state <= LOCKOUT;
                        else
                            aud_en <= 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state <= LOCKOUT;
                    end else begin
                        snz_tmr <= snz_nxt;
                        if (snz_nxt == SNZ_MAX) begin
                            state    <= RING;
                            aud_en   <= 1'b1;
                            ring_cnt <= '0;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!match)
                        state <= ARMED;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bud_ctrl.sv
// Self-checking bench for bud_ctrl: vector table, directed timeout/snooze runs, random vs model.
module tb_bud_ctrl;
    logic        clk = 1'b0;
    logic        rst, bud_en, snooze_btn, stop_btn;
    logic [15:0] now_t, bud_t;
    logic [5:0]  cnt_sec;
    logic        aud_en;
    logic [2:0]  bud_state;
    logic [1:0]  snooze_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: phase of the alarm plus seconds rung / seconds silent.
    int m_phase, m_rung, m_quiet, m_used, m_prev_sec;

    bud_ctrl dut (
        .clk(clk), .rst(rst), .bud_en(bud_en),
        .hourdec_now(now_t[15:12]), .hourone_now(now_t[11:8]),
        .mindec_now(now_t[7:4]), .minone_now(now_t[3:0]),
        .hourdec_bud(bud_t[15:12]), .hourone_bud(bud_t[11:8]),
        .mindec_bud(bud_t[7:4]), .minone_bud(bud_t[3:0]),
        .cnt_sec(cnt_sec), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .aud_en(aud_en), .bud_state(bud_state), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit match, tick;
        match = (now_t == bud_t);
        tick  = (cnt_sec != 6'(m_prev_sec));
        m_prev_sec = int'(cnt_sec);
        if (rst) begin
            m_phase = 0; m_rung = 0; m_quiet = 0; m_used = 0;
        end else if (!bud_en) begin
            m_phase = 0; m_used = 0;
        end else begin
            case (m_phase)
                0: begin m_used = 0; m_phase = match ? 4 : 1; end
                1: if (match) begin m_phase = 2; m_rung = 0; m_used = 0; end
                2: if (stop_btn) m_phase = 4;
                   else if (snooze_btn && m_used < 3) begin
                       m_phase = 3; m_used++; m_quiet = 0;
                   end else begin
                       if (tick && m_rung < 60) m_rung++;
                       if (m_rung == 60) m_phase = 4;
                   end
                3: if (stop_btn) m_phase = 4;
                   else begin
                       if (tick && m_quiet < 300) m_quiet++;
                       if (m_quiet == 300) begin m_phase = 2; m_rung = 0; end
                   end
                4: if (!match) m_phase = 1;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare outputs.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("model_state", int'(bud_state), m_phase);
        chk("model_aud", int'(aud_en), (m_phase == 2) ? 1 : 0);
        chk("model_snooze_cnt", int'(snooze_cnt), m_used);
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic sec_tick();
        cnt_sec = (cnt_sec == 6'd59) ? 6'd0 : cnt_sec + 6'd1;
    endtask

    task automatic expect_out(input string name, input int st, input int sc);
        chk({name, "_state"}, int'(bud_state), st);
        chk({name, "_aud"}, int'(aud_en), (st == 2) ? 1 : 0);
        chk({name, "_scnt"}, int'(snooze_cnt), sc);
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] now;
        logic [5:0]  sec;
        logic        snz;
        logic        stp;
        logic [2:0]  st;
        logic [1:0]  sc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        rst = 1'b1; bud_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        now_t = 16'h0729; bud_t = 16'h0730; cnt_sec = 6'd0;
        m_phase = 0; m_rung = 0; m_quiet = 0; m_used = 0; m_prev_sec = 0;

        tbl[0]  = '{1'b1, 1'b0, 16'h0729, 6'd0,  1'b0, 1'b0, 3'd0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0729, 6'd0,  1'b0, 1'b0, 3'd1, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0730, 6'd0,  1'b0, 1'b0, 3'd2, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0730, 6'd1,  1'b0, 1'b0, 3'd2, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0730, 6'd2,  1'b1, 1'b0, 3'd3, 2'd1};
        tbl[5]  = '{1'b0, 1'b1, 16'h0730, 6'd2,  1'b1, 1'b0, 3'd3, 2'd1};
        tbl[6]  = '{1'b0, 1'b1, 16'h0730, 6'd2,  1'b0, 1'b1, 3'd4, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd4, 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 16'h0731, 6'd3,  1'b0, 1'b0, 3'd1, 2'd1};
        tbl[9]  = '{1'b0, 1'b1, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd2, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 16'h0730, 6'd3,  1'b1, 1'b1, 3'd4, 2'd0};
        tbl[11] = '{1'b0, 1'b1, 16'h0731, 6'd3,  1'b0, 1'b0, 3'd1, 2'd0};
        tbl[12] = '{1'b0, 1'b1, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd2, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd0, 2'd0};
        tbl[14] = '{1'b0, 1'b1, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd4, 2'd0};
        tbl[15] = '{1'b0, 1'b0, 16'h0730, 6'd3,  1'b0, 1'b0, 3'd0, 2'd0};
        tbl[16] = '{1'b0, 1'b1, 16'h0731, 6'd3,  1'b0, 1'b0, 3'd1, 2'd0};
        tbl[17] = '{1'b0, 1'b1, 16'h0730, 6'd4,  1'b0, 1'b0, 3'd2, 2'd0};
        tbl[18] = '{1'b0, 1'b1, 16'h0730, 6'd36, 1'b1, 1'b0, 3'd3, 2'd1};
        tbl[19] = '{1'b1, 1'b1, 16'h0730, 6'd37, 1'b0, 1'b0, 3'd0, 2'd0};
        tbl[20] = '{1'b0, 1'b0, 16'h0730, 6'd37, 1'b0, 1'b0, 3'd0, 2'd0};

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; bud_en = tbl[i].en; now_t = tbl[i].now;
            cnt_sec = tbl[i].sec; snooze_btn = tbl[i].snz; stop_btn = tbl[i].stp;
            step();
            expect_out($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].sc));
        end

        // Ring timeout: still ringing after 59 ticks, locked out on the 60th.
        bud_en = 1'b1; now_t = 16'h0729; step();
        now_t = 16'h0730; step();
        expect_out("ring_entry", 2, 0);
        for (int i = 1; i <= 60; i++) begin
            sec_tick();
            step();
            if (i == 59) expect_out("ring_59", 2, 0);
        end
        expect_out("ring_timeout", 4, 0);
        now_t = 16'h0731; step();
        expect_out("lockout_exit", 1, 0);

        // Snooze chain: button beats a coincident tick; 300 ticks re-ring; 4th snooze ignored.
        now_t = 16'h0730; step();
        for (int s = 1; s <= 3; s++) begin
            snooze_btn = 1'b1; sec_tick(); step();
            expect_out($sformatf("snooze%0d", s), 3, s);
            for (int i = 1; i <= 300; i++) begin
                sec_tick();
                step();
                if (i == 299) expect_out($sformatf("snooze%0d_299", s), 3, s);
            end
            expect_out($sformatf("rering%0d", s), 2, s);
        end
        snooze_btn = 1'b1; step();
        expect_out("snooze4_ignored", 2, 3);
        bud_t = 16'h1200; step();
        expect_out("bud_change_ring", 2, 3);
        stop_btn = 1'b1; step();
        expect_out("stop_ring", 4, 3);
        step();
        expect_out("lockout_rearm", 1, 3);
        bud_t = 16'h0730; step();

        // Randomized run against the model.
        bud_en = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(99) == 0)
                now_t = (now_t == bud_t) ? 16'h0731 : bud_t;
            if ($urandom_range(2999) == 0) bud_en = ~bud_en;
            if ($urandom_range(1) == 0) sec_tick();
            snooze_btn = ($urandom_range(149) == 0);
            stop_btn   = ($urandom_range(599) == 0);
            rst        = ($urandom_range(3999) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
